// File: rtl/matmul_pkg.sv
// Shared types, constants and beat-decode helpers for the matmul result collector.
package matmul_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_GOT_B1,
        CAP_COMMIT,
        CAP_WAIT_LOW
    } cap_state_e;

    localparam logic [7:0] BEAT_OE_ON = 8'hFF;
    localparam int         ELEM_W     = 8;
    localparam int         MAT_W      = 4 * ELEM_W;

    // The tile splits each element across the two pins: high nibble on uio, low nibble on uo.
    function automatic logic [ELEM_W-1:0] decode_hi(input logic [7:0] uo, input logic [7:0] uio);
        return {uio[7:4], uo[7:4]};
    endfunction

    function automatic logic [ELEM_W-1:0] decode_lo(input logic [7:0] uo, input logic [7:0] uio);
        return {uio[3:0], uo[3:0]};
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small FIFO of whole result matrices; push is ignored when full, pop when empty.
module result_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // NOTE: storage is not reset; occupancy is governed by count_q, so stale words are never read as valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_en && !pop_en) begin
                count_q <= count_q + CW'(1);
            end else if (!push_en && pop_en) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_result_collector.sv
// Snoops the 2x2 systolic tile outputs, rebuilds result matrices from two beats,
// queues them and streams elements out over valid/ready with error status.
module matmul_result_collector
    import matmul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_uo,
    input  logic [7:0]                 in_uio,
    input  logic [7:0]                 in_oe,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ELEM_W-1:0]          res_data,
    output logic [1:0]                 res_idx,
    output logic                       res_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       proto_err,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_err
);

    logic [7:0]              uo_q, uio_q;
    logic                    beat_q;
    cap_state_e              state_q, state_d;
    logic [2*ELEM_W-1:0]     b1_q, b1_d, b2_q, b2_d;
    logic [2*ELEM_W-1:0]     beat_word;
    logic                    perr_q, perr_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    logic [1:0]              elem_q, elem_d;
    logic                    push, pop, err_evt, drop_evt, xfer;
    logic                    fifo_full, fifo_empty;
    logic [MAT_W-1:0]        head_mat;
    logic [3:0][ELEM_W-1:0]  head;

    assign beat_word = {decode_hi(uo_q, uio_q), decode_lo(uo_q, uio_q)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_q    <= '0;
            uio_q   <= '0;
            beat_q  <= 1'b0;
            state_q <= CAP_IDLE;
            b1_q    <= '0;
            b2_q    <= '0;
            perr_q  <= 1'b0;
            drop_q  <= '0;
            elem_q  <= '0;
        end else begin
            uo_q    <= in_uo;
            uio_q   <= in_uio;
            beat_q  <= (in_oe == BEAT_OE_ON);
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            perr_q  <= perr_d;
            drop_q  <= drop_d;
            elem_q  <= elem_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        push     = 1'b0;
        drop_evt = 1'b0;
        err_evt  = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (beat_q) begin
                    b1_d    = beat_word;
                    state_d = CAP_GOT_B1;
                end
            end
            CAP_GOT_B1: begin
                if (beat_q) begin
                    b2_d    = beat_word;
                    state_d = CAP_COMMIT;
                end else begin
                    err_evt = 1'b1;
                    state_d = CAP_IDLE;
                end
            end
            CAP_COMMIT: begin
                // Room is judged on the occupancy seen now; a same-cycle pop does not help.
                if (!fifo_full) push     = 1'b1;
                else            drop_evt = 1'b1;
                if (beat_q) begin
                    err_evt = 1'b1;
                    state_d = CAP_WAIT_LOW;
                end else begin
                    state_d = CAP_IDLE;
                end
            end
            CAP_WAIT_LOW: begin
                if (!beat_q) state_d = CAP_IDLE;
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // A new event in the same cycle as clr_err wins over the clear.
    always_comb begin
        perr_d = clr_err ? 1'b0 : perr_q;
        if (err_evt) perr_d = 1'b1;
        drop_d = clr_err ? '0 : drop_q;
        if (drop_evt && (drop_d != '1)) drop_d = drop_d + CNT_W'(1);
        xfer   = res_valid && res_ready;
        elem_d = xfer ? elem_q + 2'd1 : elem_q;
        pop    = xfer && (elem_q == 2'd3);
    end

    result_fifo #(
        .WIDTH (MAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({b1_q, b2_q}),
        .pop       (pop),
        .pop_data  (head_mat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head      = head_mat;
    assign res_valid = !fifo_empty;
    assign res_data  = res_valid ? head[2'd3 - elem_q] : '0;
    assign res_idx   = elem_q;
    assign res_last  = res_valid && (elem_q == 2'd3);
    assign proto_err = perr_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_matmul_result_collector.sv
// Self-checking bench: randomized beat bursts against a queue-based reference model.
module tb_matmul_result_collector;

    localparam int DEPTH    = 2;
    localparam int CNT_W    = 8;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int VW       = 13 + CW + CNT_W;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_uo = '0, in_uio = '0, in_oe = '0;
    logic             res_ready = 1'b0, clr_err = 1'b0;
    logic             res_valid, res_last, proto_err;
    logic [7:0]       res_data;
    logic [1:0]       res_idx;
    logic [CW-1:0]    fifo_count;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    matmul_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_uo      (in_uo),
        .in_uio     (in_uio),
        .in_oe      (in_oe),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_last   (res_last),
        .fifo_count (fifo_count),
        .proto_err  (proto_err),
        .drop_cnt   (drop_cnt),
        .clr_err    (clr_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-cycle input history since reset plus the queue of whole matrices.
    bit          h_oe[$], h_rdy[$], h_clr[$];
    logic [7:0]  h_uo[$], h_uio[$];
    logic [31:0] mq[$];
    int          elem;
    bit          m_perr;
    int          m_drop;

    // Stimulus plan for the current scenario.
    bit          p_oe[$], p_clr[$];
    logic [7:0]  p_uo[$], p_uio[$];

    function automatic logic [31:0] exp_mat(input logic [7:0] uo_a, input logic [7:0] uio_a,
                                            input logic [7:0] uo_b, input logic [7:0] uio_b);
        return {uio_a[7:4], uo_a[7:4], uio_a[3:0], uo_a[3:0],
                uio_b[7:4], uo_b[7:4], uio_b[3:0], uo_b[3:0]};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic        v;
        logic [31:0] hm;
        logic [7:0]  d;
        v  = (mq.size() > 0);
        hm = v ? mq[0] : 32'h0;
        d  = v ? 8'(hm >> (8 * (3 - elem))) : 8'h00;
        return {v, d, 2'(elem), v && (elem == 3), CW'(mq.size()), m_perr, CNT_W'(m_drop)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {res_valid, res_data, res_idx, res_last, fifo_count, proto_err, drop_cnt};
    endfunction

    task automatic model_reset();
        h_oe = {}; h_rdy = {}; h_clr = {}; h_uo = {}; h_uio = {};
        mq = {}; elem = 0; m_perr = 0; m_drop = 0;
    endtask

    // Applies the rules for the cycle just completed: a burst starting at s commits at s+3,
    // a lone beat at s flags an error at s+2, a third beat flags an error at commit.
    task automatic model_update();
        int m, s;
        bit xfer, err, drop, do_push;
        logic [31:0] mat;
        m = h_oe.size() - 1;
        if (m < 0) return;
        err = 0; drop = 0; do_push = 0; mat = '0;
        xfer = (mq.size() > 0) && h_rdy[m];
        if (m >= 3) begin
            s = m - 3;
            if (h_oe[s] && (s == 0 || !h_oe[s-1]) && h_oe[s+1]) begin
                mat = exp_mat(h_uo[s], h_uio[s], h_uo[s+1], h_uio[s+1]);
                if (mq.size() < DEPTH) do_push = 1; else drop = 1;
                if (h_oe[s+2]) err = 1;
            end
        end
        if (m >= 2) begin
            s = m - 2;
            if (h_oe[s] && (s == 0 || !h_oe[s-1]) && !h_oe[s+1]) err = 1;
        end
        if (xfer) begin
            if (elem == 3) begin
                void'(mq.pop_front());
                elem = 0;
            end else begin
                elem++;
            end
        end
        if (do_push) mq.push_back(mat);
        if (h_clr[m]) begin m_perr = 0; m_drop = 0; end
        if (err) m_perr = 1;
        if (drop) m_drop = (m_drop == DROP_MAX) ? DROP_MAX : m_drop + 1;
    endtask

    task automatic step(input bit oe, input logic [7:0] uo, input logic [7:0] uio,
                        input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        model_update();
        in_oe     = oe ? 8'hFF : 8'($urandom_range(0, 254));
        in_uo     = uo;
        in_uio    = uio;
        res_ready = rdy;
        clr_err   = clr;
        h_oe.push_back(oe); h_uo.push_back(uo); h_uio.push_back(uio);
        h_rdy.push_back(rdy); h_clr.push_back(clr);
        @(negedge clk);
    endtask

    task automatic step_plan(input int k, input bit rdy);
        if (k < p_oe.size()) step(p_oe[k], p_uo[k], p_uio[k], rdy, p_clr[k]);
        else                 step(1'b0, 8'($urandom), 8'($urandom), rdy, 1'b0);
    endtask

    task automatic plan_clear();
        p_oe = {}; p_clr = {}; p_uo = {}; p_uio = {};
    endtask

    task automatic plan_beat(input bit oe, input logic [7:0] uo, input logic [7:0] uio);
        p_oe.push_back(oe); p_uo.push_back(uo); p_uio.push_back(uio); p_clr.push_back(1'b0);
    endtask

    task automatic plan_burst(input int len, input int gap);
        for (int i = 0; i < len; i++) plan_beat(1'b1, 8'($urandom), 8'($urandom));
        for (int i = 0; i < gap; i++) plan_beat(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_oe = '0; res_ready = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_oe = 8'hFF; in_uo = 8'hA5; in_uio = 8'h5A; res_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4];
        logic [7:0] got_d[$];
        logic [1:0] got_i[$];
        bit         got_l[$];
        int         first = -1;
        exp_d = '{8'h13, 8'h16, 8'h2B, 8'h32};
        plan_clear();
        plan_beat(1'b1, 8'h36, 8'h11);
        plan_beat(1'b1, 8'hB2, 8'h23);
        for (int k = 0; k < 14; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (res_valid === 1'b1) begin
                if (first < 0) first = k;
                got_d.push_back(res_data); got_i.push_back(res_idx); got_l.push_back(res_last);
            end
        end
        checks++;
        if (first != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 4", first);
        end
        checks++;
        if (got_d.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 4", got_d.size());
        end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_i[i] !== 2'(i) || got_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_elem %0d: got %h/%0d/%0b expected %h/%0d/%0b",
                         i, got_d[i], got_i[i], got_l[i], exp_d[i], i, i == 3);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] m0, m1, g0, g1;
        logic [7:0]  got_d[$];
        plan_clear();
        for (int b = 0; b < 3; b++) plan_burst(2, 1);
        m0 = exp_mat(p_uo[0], p_uio[0], p_uo[1], p_uio[1]);
        m1 = exp_mat(p_uo[3], p_uio[3], p_uo[4], p_uio[4]);
        for (int k = 0; k < 15; k++) begin
            step_plan(k, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (fifo_count !== CW'(2) || drop_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL overflow_status: got count %0d drops %0d expected 2 1", fifo_count, drop_cnt);
        end
        plan_clear();
        for (int k = 0; k < 12; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_drain cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (res_valid === 1'b1) got_d.push_back(res_data);
        end
        checks++;
        if (got_d.size() != 8) begin
            errors++;
            $display("FAIL overflow_drain_len: got %0d expected 8", got_d.size());
        end else begin
            g0 = {got_d[0], got_d[1], got_d[2], got_d[3]};
            g1 = {got_d[4], got_d[5], got_d[6], got_d[7]};
            checks++;
            if (g0 !== m0 || g1 !== m1) begin
                errors++;
                $display("FAIL overflow_order: got %h %h expected %h %h", g0, g1, m0, m1);
            end
        end
    endtask

    task automatic test_short_pulse();
        logic [31:0] mexp, mgot;
        logic [7:0]  got_d[$];
        plan_clear();
        plan_beat(1'b0, 8'h00, 8'h00);
        p_clr[0] = 1'b1;
        plan_beat(1'b1, 8'h55, 8'($urandom));
        plan_burst(0, 3);
        plan_burst(2, 2);
        mexp = exp_mat(p_uo[5], p_uio[5], p_uo[6], p_uio[6]);
        for (int k = 0; k < 16; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pulse cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (k == 5) begin
                checks++;
                if (fifo_count !== '0 || res_valid !== 1'b0 || proto_err !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_not_queued: got count %0d valid %0b err %0b expected 0 0 1",
                             fifo_count, res_valid, proto_err);
                end
            end
            if (res_valid === 1'b1) got_d.push_back(res_data);
        end
        checks++;
        if (got_d.size() != 4) begin
            errors++;
            $display("FAIL pulse_followup_len: got %0d expected 4", got_d.size());
        end else begin
            mgot = {got_d[0], got_d[1], got_d[2], got_d[3]};
            checks++;
            if (mgot !== mexp) begin
                errors++;
                $display("FAIL pulse_followup: got %h expected %h", mgot, mexp);
            end
        end
    endtask

    task automatic test_long_burst();
        plan_clear();
        plan_beat(1'b0, 8'h00, 8'h00);
        p_clr[0] = 1'b1;
        plan_burst(3, 2);
        for (int k = 0; k < 10; k++) begin
            step_plan(k, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (fifo_count !== CW'(1) || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL long_status: got count %0d err %0b expected 1 1", fifo_count, proto_err);
        end
        plan_clear();
        for (int k = 0; k < 8; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long_drain cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        plan_clear();
        for (int b = 0; b < 8; b++) plan_burst(2, $urandom_range(1, 3));
        for (int k = 0; k < p_oe.size() + 40; k++) begin
            step_plan(k, bit'(k % 2));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clr_collision();
        int start;
        plan_clear();
        plan_beat(1'b0, 8'h00, 8'h00);
        p_clr[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clr_pre cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        plan_clear();
        for (int b = 0; b < 4; b++) plan_burst(2, 1);
        start = p_oe.size();
        plan_burst(3, 2);
        p_clr[start + 3] = 1'b1;
        for (int k = 0; k < p_oe.size() + 4; k++) begin
            step_plan(k, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clr_collide cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (drop_cnt !== CNT_W'(1) || proto_err !== 1'b1 || fifo_count !== CW'(2)) begin
            errors++;
            $display("FAIL clr_collide_status: got drops %0d err %0b count %0d expected 1 1 2",
                     drop_cnt, proto_err, fifo_count);
        end
    endtask

    task automatic test_saturate();
        plan_clear();
        plan_beat(1'b0, 8'h00, 8'h00);
        p_clr[0] = 1'b1;
        for (int b = 0; b < DROP_MAX + 2; b++) plan_burst(2, 1);
        for (int k = 0; k < p_oe.size() + 4; k++) begin
            step_plan(k, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL saturate cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (drop_cnt !== CNT_W'(DROP_MAX)) begin
            errors++;
            $display("FAIL saturate_value: got %0d expected %0d", drop_cnt, DROP_MAX);
        end
    endtask

    task automatic test_random();
        plan_clear();
        for (int b = 0; b < 40; b++) plan_burst($urandom_range(1, 4), $urandom_range(1, 3));
        for (int i = 0; i < p_clr.size(); i++) p_clr[i] = ($urandom_range(0, 11) == 0);
        for (int k = 0; k < p_oe.size() + 30; k++) begin
            step_plan(k, bit'($urandom_range(0, 1)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [4];
        logic [7:0] got_d[$];
        exp_d = '{8'h13, 8'h16, 8'h2B, 8'h32};
        plan_clear();
        plan_burst(2, 1);
        for (int k = 0; k < 6; k++) step_plan(k, 1'b0);
        step(1'b1, 8'h36, 8'h11, 1'b0, 1'b0);
        checks++;
        if (fifo_count === '0) begin
            errors++;
            $display("FAIL reset_mid_precond: got count 0 expected nonzero");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        do_reset();
        plan_clear();
        plan_beat(1'b1, 8'h36, 8'h11);
        plan_beat(1'b1, 8'hB2, 8'h23);
        for (int k = 0; k < 12; k++) begin
            step_plan(k, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (res_valid === 1'b1) got_d.push_back(res_data);
        end
        checks++;
        if (got_d.size() != 4) begin
            errors++;
            $display("FAIL reset_mid_len: got %0d expected 4", got_d.size());
        end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL reset_mid_elem %0d: got %h expected %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_short_pulse();
        test_long_burst();
        test_backpressure();
        test_clr_collision();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
